// File: rtl/flash_adc_pkg.sv
// Shared types and sizes for the flash ADC conversion controller.
package flash_adc_pkg;

    localparam int N_COMP   = 8;   // comparators in the thermometer ladder
    localparam int CODE_W   = 3;   // width of the encoded comparator index
    localparam int SETTLE_W = 4;   // width of the settle-cycle count
    localparam int ERR_W    = 8;   // width of the saturating bubble-error counter

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SAMPLE  = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/pe8_encode.sv
// Combinational priority encoder for an active-high thermometer word:
// reports the highest active index, whether any bit is active, and whether
// the active bits fail to form a contiguous run starting at bit 0.
module pe8_encode
    import flash_adc_pkg::*;
(
    input  logic [N_COMP-1:0] therm,
    output logic [CODE_W-1:0] code,
    output logic              gs,
    output logic              bubble
);

    // step_up[i] marks an active bit sitting directly above an inactive one;
    // any such step means the run does not start at bit 0 or has a hole.
    logic [N_COMP-1:0] step_up;

    assign step_up[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < N_COMP; gi++) begin : g_step
            assign step_up[gi] = therm[gi] & ~therm[gi-1];
        end
    endgenerate

    // Highest-index priority: later (higher) active bits overwrite earlier ones.
    always_comb begin
        code = '0;
        for (int i = 0; i < N_COMP; i++) begin
            if (therm[i]) begin
                code = CODE_W'(i);
            end
        end
    end

    assign gs     = |therm;
    assign bubble = |step_up;

endmodule

// File: rtl/flash_adc_conv_ctrl.sv
// Conversion sequencer for a flash ADC: strobes the track-and-hold, waits a
// programmable settle time, captures and encodes the comparator ladder, and
// holds the result with a valid/ready handshake. Counts bubble errors.
module flash_adc_conv_ctrl
    import flash_adc_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [SETTLE_W-1:0] settle_cyc,
    input  logic [N_COMP-1:0]   comp_low,
    output logic                sample_en,
    output logic                busy,
    output logic                valid,
    input  logic                ready,
    output logic [CODE_W-1:0]   code,
    output logic                gs,
    output logic                bubble_err,
    output logic [ERR_W-1:0]    err_cnt
);

    state_t              state_reg;
    state_t              state_next;
    logic                accept_start;

    logic [SETTLE_W-1:0] settle_lat_reg;
    logic [SETTLE_W-1:0] settle_cnt_reg;

    logic                sample_en_reg;
    logic                busy_reg;
    logic                valid_reg;
    logic [CODE_W-1:0]   code_reg;
    logic                gs_reg;
    logic                bubble_reg;
    logic [ERR_W-1:0]    err_cnt_reg;

    logic [CODE_W-1:0]   enc_code;
    logic                enc_gs;
    logic                enc_bubble;

    // The comparators are active-low; the encoder works on active-high bits.
    pe8_encode u_encode (
        .therm  (~comp_low),
        .code   (enc_code),
        .gs     (enc_gs),
        .bubble (enc_bubble)
    );

    // Next-state logic; start is only honoured from IDLE or on a DONE handoff.
    always_comb begin
        state_next   = state_reg;
        accept_start = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next   = SAMPLE;
                    accept_start = 1'b1;
                end
            end
            SAMPLE: begin
                state_next = (settle_lat_reg == '0) ? CAPTURE : SETTLE;
            end
            SETTLE: begin
                if (settle_cnt_reg == '0) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                state_next = DONE;
            end
            DONE: begin
                if (ready) begin
                    if (start) begin
                        state_next   = SAMPLE;
                        accept_start = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register plus status outputs registered from the next state, so
    // they line up with the state they describe without a decode after the flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            sample_en_reg <= 1'b0;
            busy_reg      <= 1'b0;
            valid_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sample_en_reg <= (state_next == SAMPLE);
            busy_reg      <= (state_next != IDLE);
            valid_reg     <= (state_next == DONE);
        end
    end

    // Settle value is frozen at start; the counter is loaded with N-1 on the
    // way into SETTLE so the state lasts exactly N cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_lat_reg <= '0;
            settle_cnt_reg <= '0;
        end else begin
            if (accept_start) begin
                settle_lat_reg <= settle_cyc;
            end
            if (state_reg == SAMPLE) begin
                settle_cnt_reg <= (settle_lat_reg == '0) ? '0 : settle_lat_reg - 1'b1;
            end else if (state_reg == SETTLE && settle_cnt_reg != '0) begin
                settle_cnt_reg <= settle_cnt_reg - 1'b1;
            end
        end
    end

    // Result registers load only at the closing edge of CAPTURE, so the
    // comparator inputs are ignored at every other time.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_reg    <= '0;
            gs_reg      <= 1'b0;
            bubble_reg  <= 1'b0;
            err_cnt_reg <= '0;
        end else if (state_reg == CAPTURE) begin
            code_reg   <= enc_code;
            gs_reg     <= enc_gs;
            bubble_reg <= enc_bubble;
            if (enc_bubble && err_cnt_reg != ERR_MAX) begin
                err_cnt_reg <= err_cnt_reg + 1'b1;
            end
        end
    end

    assign sample_en  = sample_en_reg;
    assign busy       = busy_reg;
    assign valid      = valid_reg;
    assign code       = code_reg;
    assign gs         = gs_reg;
    assign bubble_err = bubble_reg;
    assign err_cnt    = err_cnt_reg;

endmodule

// File: tb/tb_flash_adc_conv_ctrl.sv
// Self-checking bench for flash_adc_conv_ctrl: directed scenarios plus
// randomized conversions checked against an arithmetic reference model.
module tb_flash_adc_conv_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] settle_cyc;
    logic [7:0] comp_low;
    logic       sample_en;
    logic       busy;
    logic       valid;
    logic       ready;
    logic [2:0] code;
    logic       gs;
    logic       bubble_err;
    logic [7:0] err_cnt;

    int n_cmp;
    int n_bad;
    int exp_err;

    flash_adc_conv_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .settle_cyc (settle_cyc),
        .comp_low   (comp_low),
        .sample_en  (sample_en),
        .busy       (busy),
        .valid      (valid),
        .ready      (ready),
        .code       (code),
        .gs         (gs),
        .bubble_err (bubble_err),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: highest active index via log2, contiguity via popcount.
    task automatic model_enc(input logic [7:0] cl, output logic [2:0] ec,
                             output logic eg, output logic eb);
        int a;
        int hi;
        a  = int'(~cl) & 255;
        eg = (a != 0);
        hi = (a == 0) ? 0 : $clog2(a + 1) - 1;
        ec = 3'(hi);
        eb = eg && ($countones(a) != hi + 1);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; ready = 1'b0;
        settle_cyc = 4'd0; comp_low = 8'hFF;
        tick();
        tick();
        n_cmp++;
        if ({sample_en, busy, valid, code, gs, bubble_err, err_cnt} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got se=%0b busy=%0b valid=%0b code=%0d gs=%0b bub=%0b err=%0d want all 0",
                     sample_en, busy, valid, code, gs, bubble_err, err_cnt);
        end
        exp_err = 0;
        rst = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: got busy=%0b want 0", busy);
        end
    endtask

    // One full conversion. from_b2b: start was already accepted by the previous
    // call's DONE handoff. to_b2b: leave DONE straight into a new conversion.
    task automatic test_conversion(input int settle, input logic [7:0] val, input int hold,
                                   input bit from_b2b, input bit to_b2b, input int next_settle);
        logic [2:0] ec;
        logic       eg;
        logic       eb;
        model_enc(val, ec, eg, eb);
        if (!from_b2b) begin
            settle_cyc = 4'(settle);
            start      = 1'b1;
            ready      = 1'b0;
            comp_low   = 8'($urandom);
        end
        tick();
        n_cmp++;
        if ({sample_en, busy, valid} !== 3'b110) begin
            n_bad++;
            $display("FAIL sample_cycle: got se/busy/valid=%b want 110 (settle=%0d)",
                     {sample_en, busy, valid}, settle);
        end
        start      = 1'b0;
        ready      = 1'b0;
        settle_cyc = 4'($urandom);
        comp_low   = 8'($urandom);
        for (int c = 2; c <= settle + 2; c++) begin
            tick();
            n_cmp++;
            if ({sample_en, busy, valid} !== 3'b010) begin
                n_bad++;
                $display("FAIL wait_cycle: cycle %0d got se/busy/valid=%b want 010 (settle=%0d)",
                         c, {sample_en, busy, valid}, settle);
            end
            comp_low = (c == settle + 2) ? val : 8'($urandom);
            start    = 1'($urandom);
        end
        start = 1'b0;
        if (eb && exp_err < 255) exp_err++;
        tick();
        n_cmp++;
        if ({sample_en, busy, valid} !== 3'b011) begin
            n_bad++;
            $display("FAIL valid_cycle: cycle %0d got se/busy/valid=%b want 011",
                     settle + 3, {sample_en, busy, valid});
        end
        n_cmp++;
        if ({code, gs, bubble_err} !== {ec, eg, eb} || err_cnt !== 8'(exp_err)) begin
            n_bad++;
            $display("FAIL result: comp_low=%h got code=%0d gs=%0b bub=%0b err=%0d want code=%0d gs=%0b bub=%0b err=%0d",
                     val, code, gs, bubble_err, err_cnt, ec, eg, eb, exp_err);
        end
        for (int h = 0; h < hold; h++) begin
            comp_low = 8'($urandom);
            start    = 1'($urandom);
            ready    = 1'b0;
            tick();
            n_cmp++;
            if ({sample_en, busy, valid, code, gs, bubble_err} !== {3'b011, ec, eg, eb}
                || err_cnt !== 8'(exp_err)) begin
                n_bad++;
                $display("FAIL hold_stable: hold %0d got se=%0b valid=%0b code=%0d gs=%0b bub=%0b err=%0d want se=0 valid=1 code=%0d gs=%0b bub=%0b err=%0d",
                         h, sample_en, valid, code, gs, bubble_err, err_cnt, ec, eg, eb, exp_err);
            end
        end
        ready = 1'b1;
        start = to_b2b;
        if (to_b2b) settle_cyc = 4'(next_settle);
        if (!to_b2b) begin
            tick();
            n_cmp++;
            if ({sample_en, busy, valid} !== 3'b000) begin
                n_bad++;
                $display("FAIL accept_idle: got se/busy/valid=%b want 000", {sample_en, busy, valid});
            end
            ready = 1'b0;
        end
    endtask

    task automatic test_directed();
        test_conversion(2, 8'hF0, 0, 1'b0, 1'b0, 0);
        test_conversion(0, 8'hFF, 0, 1'b0, 1'b0, 0);
        test_conversion(4, 8'h00, 0, 1'b0, 1'b0, 0);
        test_conversion(1, 8'hDE, 0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_hold_back_to_back();
        test_conversion(1, 8'h7F, 10, 1'b0, 1'b1, 3);
        test_conversion(3, 8'h3C, 2, 1'b1, 1'b0, 0);
    endtask

    task automatic test_bubble_saturate();
        for (int i = 0; i < 260; i++) begin
            test_conversion(int'($urandom_range(0, 2)), 8'hDE, 0, 1'b0, 1'b0, 0);
        end
        n_cmp++;
        if (err_cnt !== 8'd255) begin
            n_bad++;
            $display("FAIL err_saturate: got err_cnt=%0d want 255", err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        settle_cyc = 4'd6;
        comp_low   = 8'hDE;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst   = 1'b1;
        start = 1'b1;
        ready = 1'b1;
        tick();
        exp_err = 0;
        n_cmp++;
        if ({sample_en, busy, valid, code, gs, bubble_err, err_cnt} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset_mid: got se=%0b busy=%0b valid=%0b code=%0d gs=%0b bub=%0b err=%0d want all 0",
                     sample_en, busy, valid, code, gs, bubble_err, err_cnt);
        end
        rst   = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        tick();
        n_cmp++;
        if ({sample_en, busy, valid} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_priority: got se/busy/valid=%b want 000", {sample_en, busy, valid});
        end
        test_conversion(3, 8'hF8, 0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_random();
        bit chained;
        bit next_b2b;
        int settle;
        int next_settle;
        chained = 1'b0;
        settle  = int'($urandom_range(0, 15));
        for (int i = 0; i < 40; i++) begin
            next_b2b    = (i != 39) && 1'($urandom);
            next_settle = int'($urandom_range(0, 15));
            test_conversion(settle, 8'($urandom), int'($urandom_range(0, 3)),
                            chained, next_b2b, next_settle);
            chained = next_b2b;
            settle  = next_b2b ? next_settle : int'($urandom_range(0, 15));
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        exp_err = 0;
        test_reset();
        test_directed();
        test_hold_back_to_back();
        test_bubble_saturate();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
